// File: rtl/mem_io_bridge.sv
// CPU load/store steering into data BRAM, IO_CH memory-mapped IO channels or an unmapped hole.
// Latency: response pulse 2 cycles after accept, 2+MEM_LAT for data-memory loads.
// Backpressure: one access in flight; req_ready low from issue until the response cycle ends.
module mem_io_bridge #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                MEM_AW       = 14,
  parameter int                MEM_LAT      = 1,
  parameter logic [ADDR_W-1:0] IO_BASE      = 32'hFFFF_FC00,
  parameter int                IO_CH        = 4,
  parameter int                IO_SPAN_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [IO_CH-1:0]        io_rd,
  output logic [IO_CH-1:0]        io_wr,
  output logic [IO_SPAN_LOG2-1:0] io_addr,
  output logic [DATA_W-1:0]       io_wdata,
  input  logic [IO_CH*DATA_W-1:0] io_rdata
);

  localparam int CH_W = (IO_CH > 1) ? $clog2(IO_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    wr_q, is_mem_q, is_io_q;
  logic [CH_W-1:0]         ch_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [MEM_AW-1:0]       mem_addr_q;
  logic [IO_SPAN_LOG2-1:0] io_addr_q;
  logic                    mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [IO_CH-1:0]        io_rd_q, io_rd_d, io_wr_q, io_wr_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

  logic [ADDR_W-1:0]       io_off, ch_full;
  logic                    dec_mem, dec_io, accept;
  logic [CH_W-1:0]         dec_ch;
  logic [IO_CH-1:0]        dec_onehot;
  logic [DATA_W-1:0]       io_sel;

  assign accept = (state_q == IDLE) && req_valid;

  // Classify the incoming address; the channel index only matters when it is in range.
  always_comb begin
    io_off     = req_addr - IO_BASE;
    ch_full    = io_off >> IO_SPAN_LOG2;
    dec_mem    = (req_addr < IO_BASE);
    dec_io     = !dec_mem && (ch_full < ADDR_W'(IO_CH));
    dec_ch     = ch_full[CH_W-1:0];
    dec_onehot = '0;
    dec_onehot[dec_ch] = 1'b1;
  end

  // Pick the read-data slice of the captured channel.
  always_comb begin
    io_sel = '0;
    for (int k = 0; k < IO_CH; k++) begin
      if (ch_q == CH_W'(k)) io_sel = io_rdata[k*DATA_W +: DATA_W];
    end
  end

  // Next state; strobes are computed at accept so they appear registered in ISSUE only.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    io_rd_d     = '0;
    io_wr_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = ISSUE;
          mem_en_d = dec_mem;
          mem_we_d = dec_mem && req_write;
          if (dec_io) begin
            if (req_write) io_wr_d = dec_onehot;
            else           io_rd_d = dec_onehot;
          end
        end
      end
      ISSUE: begin
        if (is_mem_q && !wr_q) begin
          state_d = WAIT;
          cnt_d   = 3'(MEM_LAT);
        end else begin
          // IO read data is sampled here, while io_rd is still asserted.
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !is_mem_q && !is_io_q;
          rsp_rdata_d = (is_io_q && !wr_q) ? io_sel : '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d     = RESP;
          cnt_d       = 3'd0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request and its decode; held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b0;
      is_mem_q   <= 1'b0;
      is_io_q    <= 1'b0;
      ch_q       <= '0;
      wdata_q    <= '0;
      mem_addr_q <= '0;
      io_addr_q  <= '0;
    end else if (accept) begin
      wr_q       <= req_write;
      is_mem_q   <= dec_mem;
      is_io_q    <= dec_io;
      ch_q       <= dec_ch;
      wdata_q    <= req_wdata;
      mem_addr_q <= req_addr[MEM_AW+1:2];
      io_addr_q  <= io_off[IO_SPAN_LOG2-1:0];
    end
  end

  // State, strobe and response registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      io_rd_q     <= '0;
      io_wr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      io_rd_q     <= io_rd_d;
      io_wr_q     <= io_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: reset state, table vectors, held-request and reset-abort
// sequences, then random accesses against a spec-level reference model.
module tb_mem_io_bridge;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          MAW  = 14;
  localparam int          LAT  = 2;
  localparam int          NCH  = 4;
  localparam int          SPAN = 4;
  localparam logic [31:0] IOB  = 32'hFFFF_FC00;

  logic              clk, rst, req_valid, req_write, req_ready;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata, rsp_rdata, mem_wdata, mem_rdata, io_wdata;
  logic              rsp_valid, rsp_err, mem_en, mem_we;
  logic [MAW-1:0]    mem_addr;
  logic [NCH-1:0]    io_rd, io_wr;
  logic [SPAN-1:0]   io_addr;
  logic [NCH*DW-1:0] io_rdata;

  mem_io_bridge #(.DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW), .MEM_LAT(LAT), .IO_BASE(IOB),
                  .IO_CH(NCH), .IO_SPAN_LOG2(SPAN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata));

  always #5 clk = ~clk;

  // BRAM with LAT-cycle read pipeline; data is junk except in the one valid cycle.
  bit [31:0] bram    [1<<MAW];
  bit [31:0] ref_mem [1<<MAW];
  bit [31:0] pipe_d  [LAT];
  bit        pipe_v  [LAT];
  bit        preload;
  always @(posedge clk) begin
    if (preload) bram[8] <= 32'h1234_5678;
    else if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
    pipe_d[0] <= bram[mem_addr];
    pipe_v[0] <= mem_en && !mem_we;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end
  assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0_BAD0;

  logic [31:0] io_regs [NCH];
  always_comb begin
    for (int k = 0; k < NCH; k++) io_rdata[k*DW +: DW] = io_regs[k];
  end

  typedef struct {
    int lat; logic [31:0] rdata; logic err; int mem_en_n; int mem_we_n;
    logic [3:0] io_rd; logic [3:0] io_wr; logic [13:0] maddr; logic [3:0] ioaddr; logic [31:0] wdata;
  } exp_t;

  typedef struct {
    int rsp_cyc; int rsp_n; int mem_en_n; int mem_we_n; int io_n; int strobe_cyc;
    logic [31:0] rdata; logic [31:0] wdata; logic err; logic [3:0] io_rd_seen; logic [3:0] io_wr_seen;
    logic [13:0] maddr; logic [3:0] ioaddr; bit excl_bad; bit ready_bad; bit ready_after; bit hold_ok;
  } obs_t;

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wd; int ioch; logic [31:0] iov; exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                               input int ioch, input logic [31:0] iov, input int lat,
                               input logic [31:0] rd, input logic err, input int men, input int mwe,
                               input logic [3:0] iord, input logic [3:0] iowr,
                               input logic [13:0] maddr, input logic [3:0] ioaddr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wd = wd; v.ioch = ioch; v.iov = iov;
    v.e.lat = lat; v.e.rdata = rd; v.e.err = err; v.e.mem_en_n = men; v.e.mem_we_n = mwe;
    v.e.io_rd = iord; v.e.io_wr = iowr; v.e.maddr = maddr; v.e.ioaddr = ioaddr; v.e.wdata = wd;
    return v;
  endfunction

  // Reference: region by plain address arithmetic, data from the bench's own memory image.
  function automatic exp_t model(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e; longint off; int ch; bit is_mem, is_io;
    e = '{default:0};
    is_mem = (addr < IOB);
    off    = longint'(addr) - longint'(IOB);
    ch     = is_mem ? -1 : int'(off / (1 << SPAN));
    is_io  = !is_mem && (ch < NCH);
    e.lat      = (is_mem && !wr) ? 2 + LAT : 2;
    e.err      = !is_mem && !is_io;
    e.mem_en_n = is_mem ? 1 : 0;
    e.mem_we_n = (is_mem && wr) ? 1 : 0;
    if (is_io) begin
      if (wr) e.io_wr[ch] = 1'b1;
      else    e.io_rd[ch] = 1'b1;
    end
    e.maddr  = 14'((addr / 4) % (1 << MAW));
    e.ioaddr = is_io ? 4'(off % (1 << SPAN)) : 4'd0;
    e.wdata  = wd;
    if (!wr) e.rdata = is_mem ? ref_mem[e.maddr] : (is_io ? io_regs[ch] : 32'd0);
    return e;
  endfunction

  task automatic ref_update(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    if (wr && addr < IOB) ref_mem[(addr / 4) % (1 << MAW)] = wd;
  endtask

  // Drive one request from an idle negedge and observe cycles T+1.. at negedges.
  task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            output obs_t o);
    int w;
    o = '{default:0};
    o.rsp_cyc = -1; o.strobe_cyc = -1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (mem_en) begin
        o.mem_en_n++;
        if (o.strobe_cyc < 0) o.strobe_cyc = k;
        o.maddr = mem_addr; o.wdata = mem_wdata;
      end
      if (mem_we) o.mem_we_n++;
      if (|io_rd || |io_wr) begin
        o.io_n++;
        if (o.strobe_cyc < 0) o.strobe_cyc = k;
        o.ioaddr = io_addr; o.wdata = io_wdata;
      end
      o.io_rd_seen |= io_rd;
      o.io_wr_seen |= io_wr;
      if (int'(mem_en) + int'(|io_rd) + int'(|io_wr) > 1 || $countones(io_rd) > 1 ||
          $countones(io_wr) > 1) o.excl_bad = 1;
      if (o.rsp_cyc < 0 && req_ready) o.ready_bad = 1;
      if (rsp_valid) begin
        o.rsp_n++;
        if (o.rsp_cyc < 0) begin o.rsp_cyc = k; o.rdata = rsp_rdata; o.err = rsp_err; end
      end
      if (o.rsp_cyc >= 0 && k == o.rsp_cyc + 1) begin
        o.ready_after = req_ready;
        o.hold_ok = (rsp_rdata === o.rdata);
        break;
      end
    end
  endtask

  task automatic compare(input string t, input obs_t o, input exp_t e);
    bit any;
    any = (e.mem_en_n != 0) || ((e.io_rd | e.io_wr) != 0);
    chk({t, ".latency"},     o.rsp_cyc, e.lat);
    chk({t, ".rsp_pulses"},  o.rsp_n, 1);
    chk({t, ".rdata"},       o.rdata, e.rdata);
    chk({t, ".err"},         o.err, e.err);
    chk({t, ".mem_en_cyc"},  o.mem_en_n, e.mem_en_n);
    chk({t, ".mem_we_cyc"},  o.mem_we_n, e.mem_we_n);
    chk({t, ".io_rd"},       o.io_rd_seen, e.io_rd);
    chk({t, ".io_wr"},       o.io_wr_seen, e.io_wr);
    chk({t, ".io_cyc"},      o.io_n, ((e.io_rd | e.io_wr) != 0) ? 1 : 0);
    chk({t, ".strobe_cyc"},  o.strobe_cyc, any ? 1 : -1);
    if (e.mem_en_n != 0) chk({t, ".mem_addr"}, o.maddr, e.maddr);
    if ((e.io_rd | e.io_wr) != 0) chk({t, ".io_addr"}, o.ioaddr, e.ioaddr);
    if (e.mem_we_n != 0 || e.io_wr != 0) chk({t, ".wdata"}, o.wdata, e.wdata);
    chk({t, ".exclusive"},   o.excl_bad, 0);
    chk({t, ".ready_low"},   o.ready_bad, 0);
    chk({t, ".ready_back"},  o.ready_after, 1);
    chk({t, ".rdata_hold"},  o.hold_ok, 1);
  endtask

  task automatic set_io(input int ch, input logic [31:0] v);
    for (int k = 0; k < NCH; k++) io_regs[k] = 32'h5A5A_0000 | k;
    if (ch >= 0) io_regs[ch] = v;
  endtask

  initial begin
    vec_t  vt [13];
    obs_t  o;
    exp_t  e;
    int    acc_mask, pulse_mask, n_rsp, n_strb;
    logic  wr;
    logic [31:0] addr, wd;

    clk = 0; rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    preload = 1; set_io(-1, 0);
    ref_mem[8] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("reset.ready",   req_ready, 1);
    chk("reset.ctl",     {rsp_valid, rsp_err, mem_en, mem_we, io_rd, io_wr}, 0);
    chk("reset.data",    rsp_rdata | mem_wdata | io_wdata, 0);
    chk("reset.addr",    {mem_addr, io_addr}, 0);
    preload = 0; rst = 0;
    @(negedge clk);

    //           wr    addr           wdata          ioch iov           lat rdata         err men mwe iord     iowr     maddr     ioaddr
    vt[0]  = mkv(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, -1, 0,             2, 32'h0,         0, 1, 1, 4'b0000, 4'b0000, 14'h0004, 4'h0);
    vt[1]  = mkv(1'b0, 32'h0000_0020, 32'h0,         -1, 0,             4, 32'h1234_5678, 0, 1, 0, 4'b0000, 4'b0000, 14'h0008, 4'h0);
    vt[2]  = mkv(1'b0, 32'h0000_0010, 32'h0,         -1, 0,             4, 32'hDEAD_BEEF, 0, 1, 0, 4'b0000, 4'b0000, 14'h0004, 4'h0);
    vt[3]  = mkv(1'b0, 32'hFFFF_FC14, 32'h0,          1, 32'h0000_00A5, 2, 32'h0000_00A5, 0, 0, 0, 4'b0010, 4'b0000, 14'h0000, 4'h4);
    vt[4]  = mkv(1'b1, 32'hFFFF_FC40, 32'h0BAD_C0DE, -1, 0,             2, 32'h0,         1, 0, 0, 4'b0000, 4'b0000, 14'h0000, 4'h0);
    vt[5]  = mkv(1'b1, 32'hFFFF_FC3F, 32'h1122_3344, -1, 0,             2, 32'h0,         0, 0, 0, 4'b0000, 4'b1000, 14'h0000, 4'hF);
    vt[6]  = mkv(1'b0, 32'hFFFF_FC3F, 32'h0,          3, 32'h7766_5544, 2, 32'h7766_5544, 0, 0, 0, 4'b1000, 4'b0000, 14'h0000, 4'hF);
    vt[7]  = mkv(1'b0, 32'hFFFF_FC40, 32'h0,         -1, 0,             2, 32'h0,         1, 0, 0, 4'b0000, 4'b0000, 14'h0000, 4'h0);
    vt[8]  = mkv(1'b1, 32'hFFFF_FBFC, 32'hCAFE_F00D, -1, 0,             2, 32'h0,         0, 1, 1, 4'b0000, 4'b0000, 14'h3EFF, 4'h0);
    vt[9]  = mkv(1'b0, 32'hFFFF_FBFF, 32'h0,         -1, 0,             4, 32'hCAFE_F00D, 0, 1, 0, 4'b0000, 4'b0000, 14'h3EFF, 4'h0);
    vt[10] = mkv(1'b0, 32'hFFFF_FC00, 32'h0,          0, 32'h1357_9BDF, 2, 32'h1357_9BDF, 0, 0, 0, 4'b0001, 4'b0000, 14'h0000, 4'h0);
    vt[11] = mkv(1'b1, 32'hFFFF_FC2C, 32'h55AA_55AA, -1, 0,             2, 32'h0,         0, 0, 0, 4'b0000, 4'b0100, 14'h0000, 4'hC);
    vt[12] = mkv(1'b0, 32'hFFFF_FFFF, 32'h0,         -1, 0,             2, 32'h0,         1, 0, 0, 4'b0000, 4'b0000, 14'h0000, 4'h0);

    for (int i = 0; i < 13; i++) begin
      set_io(vt[i].ioch, vt[i].iov);
      run_access(vt[i].wr, vt[i].addr, vt[i].wd, o);
      compare($sformatf("vec%0d", i), o, vt[i].e);
      ref_update(vt[i].wr, vt[i].addr, vt[i].wd);
    end

    // Held req_valid: three IO stores to channel 2, accepted every third cycle.
    acc_mask = 0; pulse_mask = 0;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      if (|io_wr) begin
        pulse_mask |= (1 << c);
        chk("held.io_wr", io_wr, 4'b0100);
        chk("held.wdata", io_wdata, 32'hA000_0000 + 32'(c - 1));
      end
      if (c < 8) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hFFFF_FC24; req_wdata = 32'hA000_0000 + 32'(c);
      end else req_valid = 1'b0;
      if (req_valid && req_ready) acc_mask |= (1 << c);
    end
    chk("held.accepts", acc_mask, 32'h49);
    chk("held.pulses",  pulse_mask, 32'h92);

    // Random accesses against the reference model.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: addr = $urandom_range(0, 511);
        4:          addr = IOB - 32'd1 - 32'($urandom_range(0, 63));
        5, 6, 7:    addr = IOB + 32'($urandom_range(0, 63));
        8:          addr = IOB + 32'd64 + 32'($urandom_range(0, 959));
        default: begin
          case ($urandom_range(0, 3))
            0: addr = IOB + 32'd63;
            1: addr = IOB + 32'd64;
            2: addr = IOB - 32'd1;
            default: addr = IOB;
          endcase
        end
      endcase
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      for (int k = 0; k < NCH; k++) io_regs[k] = $urandom;
      e = model(wr, addr, wd);
      run_access(wr, addr, wd, o);
      compare($sformatf("rnd%0d", i), o, e);
      ref_update(wr, addr, wd);
    end

    // Reset during the WAIT of a memory load aborts it immediately.
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstw.issue_mem_en", mem_en, 1);
    @(negedge clk);
    chk("rstw.in_wait_ready", req_ready, 0);
    rst = 1'b1;
    #1;
    chk("rstw.strobes", {mem_en, mem_we, io_rd, io_wr}, 0);
    chk("rstw.ready",   req_ready, 1);
    chk("rstw.rsp",     {rsp_valid, rsp_err}, 0);
    chk("rstw.rdata",   rsp_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    n_rsp = 0; n_strb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
      if (mem_en || |io_rd || |io_wr) n_strb++;
    end
    chk("rstw.no_rsp_after",    n_rsp, 0);
    chk("rstw.no_strobe_after", n_strb, 0);
    chk("rstw.ready_after",     req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sequential successor to the combinational memory/IO steering stage; sits between the CPU load/store path and the data BRAM and IO peripherals.
- Decodes each address into data memory, one of IO_CH memory-mapped IO channels, or an unmapped hole.
- Issues single-cycle registered strobes and waits out the BRAM read latency.
- Returns read data or an error through a valid/ready handshake. No tristate write bus.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, CPU address width.
- MEM_AW, 14, data-memory word-address width.
- MEM_LAT, 1, BRAM read latency in cycles; legal range 1..4.
- IO_BASE, 32'hFFFF_FC00, first IO byte address.
- IO_CH, 4, number of IO channels, 1..8.
- IO_SPAN_LOG2, 4, log2 of bytes per IO channel.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU access request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address (alu result)
- req_wdata  in  DATA_W  store data from register file
- req_ready  out  1  bridge can accept a request
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  load data to register file
- rsp_err  out  1  unmapped IO access, qualified by rsp_valid
- mem_en  out  1  BRAM enable strobe
- mem_we  out  1  BRAM write strobe
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data
- io_rd  out  IO_CH  one-hot read strobe (chip select)
- io_wr  out  IO_CH  one-hot write strobe (chip select)
- io_addr  out  IO_SPAN_LOG2  byte offset within the selected channel
- io_wdata  out  DATA_W  IO write data
- io_rdata  in  IO_CH*DATA_W  per-channel read data; channel k occupies bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset (asynchronous, immediate): state IDLE, count 0, every output 0 except req_ready = 1.
- Reset mid-access aborts the access: no strobe or response completes.
- Decode (at accept):
  - addr < IO_BASE: memory.
  - Otherwise ch = (addr - IO_BASE) >> IO_SPAN_LOG2; ch < IO_CH: IO channel ch; else unmapped.
  - mem_addr = addr[MEM_AW+1:2].
  - io_addr = (addr - IO_BASE)[IO_SPAN_LOG2-1:0].
- Capture: on accept, register addr, wdata, write flag and the decode result. mem_wdata, io_wdata, mem_addr and io_addr hold the captured values until the next accept.
- FSM states: IDLE, ISSUE, WAIT, RESP. Accept cycle = T.
  - IDLE: req_ready = 1. On req_valid, go to ISSUE.
  - ISSUE (cycle T+1): exactly one strobe is high for exactly this cycle.
    - Memory: mem_en, plus mem_we if write.
    - IO: io_wr[ch] or io_rd[ch].
    - Unmapped: no strobe.
    - Next state: WAIT for a memory read (count loaded with MEM_LAT); RESP otherwise.
    - IO read samples io_rdata slice ch at the end of this cycle.
  - WAIT: count decrements each cycle. mem_rdata is sampled at the end of the cycle where count = 1, then go to RESP.
  - RESP: rsp_valid = 1 for one cycle, then IDLE.
- Response contents:
  - rsp_rdata = sampled data for loads; 0 for stores and unmapped accesses.
  - rsp_rdata holds its value until the next RESP.
  - rsp_err = 1 only in RESP of an unmapped access.
- Latency (rsp_valid cycle):
  - Store, IO load, unmapped: T+2.
  - Memory load: T+2+MEM_LAT.
- req_ready = 0 in ISSUE, WAIT and RESP. req_valid held in those states is ignored and not queued; the next accept is possible in the cycle after RESP.
- Unmapped store writes nothing anywhere.
- The address at IO_BASE + IO_CH*2^IO_SPAN_LOG2 - 1 maps to the last channel; the next byte address is unmapped.
- At most one of mem_en, |io_rd, |io_wr is high in any cycle.

Test Plan:
- Reset asserted while in WAIT of a memory load -> all strobes 0 immediately; no rsp_valid afterwards; req_ready = 1.
- Store addr 0x0000_0010, data 0xDEADBEEF at T -> T+1: mem_en = mem_we = 1, mem_addr = 4, mem_wdata = 0xDEADBEEF; T+2: rsp_valid = 1, rsp_rdata = 0.
- MEM_LAT = 2, load addr 0x20, BRAM returns 0x12345678 -> mem_en at T+1 only; rsp_valid at T+4 with rsp_rdata = 0x12345678; req_ready low from T+1 to T+4.
- Load addr 0xFFFF_FC14 (channel 1, offset 4), io_rdata slice 1 = 0x0000_00A5 -> io_rd = 4'b0010 at T+1; io_addr = 4; rsp at T+2 with rsp_rdata = 0xA5, rsp_err = 0.
- Store addr 0xFFFF_FC40 (IO_CH = 4) -> no strobe at T+1; T+2: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- req_valid held high for 3 back-to-back IO stores -> accepts at T, T+3, T+6; io_wr pulses exactly once per store.
